reaction_round_ctrl: RTL and testbench

REACTION_ROUND_CTRL -- requirements
Module: reaction_round_ctrl

---
 rtl/reaction_round_ctrl.sv | 119 +++++++++++
 tb/tb_reaction_round_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reaction_round_ctrl.sv
// Reaction-time game round controller: random pre-GO delay, false-start detection,
// reaction measurement in ms ticks with a timeout ceiling of MAX_MS.
//
//   state            | meaning
//   S_IDLE           | no round since reset
//   S_WAIT           | counting the random pre-GO delay; any react is a false start
//   S_GO             | GO lamp lit, counting reaction ms up to MAX_MS
//   S_DONE_OR_EARLY  | result held; r_early selects EARLY vs DONE
module reaction_round_ctrl #(
  parameter logic [15:0] MAX_MS = 16'd9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        react,
  input  logic [15:0] delay_target,
  output logic        busy,
  output logic        led_go,
  output logic        done,
  output logic        early,
  output logic        timeout,
  output logic [15:0] reaction_ms
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE_OR_EARLY
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_ms_cnt, w_ms_cnt_nxt;
  logic [15:0] r_tgt, w_tgt_nxt;
  logic [15:0] r_reaction_ms, w_reaction_ms_nxt;
  logic        r_early, w_early_nxt;
  logic        r_timeout, w_timeout_nxt;
  logic [15:0] w_cmp_ref;
  logic        w_match;

  // One shared comparator: delay target while waiting, ceiling while in GO.
  assign w_cmp_ref = (r_state == S_GO) ? MAX_MS : r_tgt;
  assign w_match   = &(r_ms_cnt ~^ w_cmp_ref);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ms_cnt      <= '0;
      r_tgt         <= '0;
      r_reaction_ms <= '0;
      r_early       <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ms_cnt      <= w_ms_cnt_nxt;
      r_tgt         <= w_tgt_nxt;
      r_reaction_ms <= w_reaction_ms_nxt;
      r_early       <= w_early_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_ms_cnt_nxt      = r_ms_cnt;
    w_tgt_nxt         = r_tgt;
    w_reaction_ms_nxt = r_reaction_ms;
    w_early_nxt       = r_early;
    w_timeout_nxt     = r_timeout;
    case (r_state)
      S_IDLE, S_DONE_OR_EARLY: begin
        if (start) begin
          w_state_nxt   = S_WAIT;
          w_tgt_nxt     = delay_target;
          w_ms_cnt_nxt  = '0;
          w_early_nxt   = 1'b0;
          w_timeout_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (react) begin
          w_state_nxt   = S_DONE_OR_EARLY;
          w_early_nxt   = 1'b1;
          w_timeout_nxt = 1'b0;
        end else if (w_match) begin
          w_state_nxt  = S_GO;
          w_ms_cnt_nxt = '0;
        end else if (tick) begin
          w_ms_cnt_nxt = r_ms_cnt + 16'd1;
        end
      end
      S_GO: begin
        if (react) begin
          w_state_nxt       = S_DONE_OR_EARLY;
          w_early_nxt       = 1'b0;
          w_timeout_nxt     = 1'b0;
          w_reaction_ms_nxt = r_ms_cnt;
        end else if (w_match) begin
          w_state_nxt       = S_DONE_OR_EARLY;
          w_early_nxt       = 1'b0;
          w_timeout_nxt     = 1'b1;
          w_reaction_ms_nxt = MAX_MS;
        end else if (tick) begin
          w_ms_cnt_nxt = r_ms_cnt + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy        = (r_state == S_WAIT) || (r_state == S_GO);
  assign led_go      = (r_state == S_GO);
  assign done        = (r_state == S_DONE_OR_EARLY) && !r_early;
  assign early       = (r_state == S_DONE_OR_EARLY) && r_early;
  assign timeout     = (r_state == S_DONE_OR_EARLY) && !r_early && r_timeout;
  assign reaction_ms = r_reaction_ms;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Bench for reaction_round_ctrl: default-ceiling instance plus a MAX_MS=20 instance
// sharing one stimulus; expected outputs queued per vector and checked after the edge.
module tb_reaction_round_ctrl;

  logic        clk = 1'b0;
  logic        rst, tick, start, react;
  logic [15:0] delay_target;

  logic        a_busy, a_led, a_done, a_early, a_tmo;
  logic [15:0] a_rms;
  logic        b_busy, b_led, b_done, b_early, b_tmo;
  logic [15:0] b_rms;

  reaction_round_ctrl u_dut_a (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .react(react),
    .delay_target(delay_target),
    .busy(a_busy), .led_go(a_led), .done(a_done), .early(a_early),
    .timeout(a_tmo), .reaction_ms(a_rms)
  );

  reaction_round_ctrl #(.MAX_MS(16'd20)) u_dut_b (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .react(react),
    .delay_target(delay_target),
    .busy(b_busy), .led_go(b_led), .done(b_done), .early(b_early),
    .timeout(b_tmo), .reaction_ms(b_rms)
  );

  always #5 clk = ~clk;

  // in = {rst, tick, start, react}; fl = {busy, led_go, done, early, timeout}
  typedef struct {
    string       name;
    bit          sel;
    logic [3:0]  in;
    logic [15:0] dly;
    logic [4:0]  fl;
    logic [15:0] rms;
  } vec_t;

  vec_t        exp_q[$];
  vec_t        table_v[4];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic vec_t mk(string n, bit sel, logic [3:0] in, logic [15:0] dly,
                              logic [4:0] fl, logic [15:0] rms);
    vec_t v;
    v.name = n; v.sel = sel; v.in = in; v.dly = dly; v.fl = fl; v.rms = rms;
    return v;
  endfunction

  task automatic drv(input logic [3:0] in, input logic [15:0] dly);
    {rst, tick, start, react} = in;
    delay_target = dly;
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) drv(4'b0100, 16'd0);
  endtask

  task automatic apply(input vec_t v);
    vec_t        e;
    logic [20:0] act, req;
    exp_q.push_back(v);
    drv(v.in, v.dly);
    e = exp_q.pop_front();
    act = e.sel ? {b_busy, b_led, b_done, b_early, b_tmo, b_rms}
                : {a_busy, a_led, a_done, a_early, a_tmo, a_rms};
    req = {e.fl, e.rms};
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got flags=%b ms=%0d, want flags=%b ms=%0d",
               e.name, act[20:16], act[15:0], req[20:16], req[15:0]);
    end
  endtask

  initial begin
    {rst, tick, start, react} = 4'b1000;
    delay_target = 16'd0;
    @(posedge clk);
    #1;

    table_v[0] = mk("rst_prio",     0, 4'b1011, 16'd5, 5'b00000, 16'd0);
    table_v[1] = mk("idle_react",   0, 4'b0001, 16'd5, 5'b00000, 16'd0);
    table_v[2] = mk("rst_again",    0, 4'b1000, 16'd5, 5'b00000, 16'd0);
    table_v[3] = mk("start_at_rel", 0, 4'b0010, 16'd5, 5'b10000, 16'd0);
    for (int i = 0; i < 4; i++) apply(table_v[i]);

    // normal round: delay 5, react after 237 GO ticks
    run_ticks(4);
    apply(mk("wait_5th_tick", 0, 4'b0100, 16'd0, 5'b10000, 16'd0));
    apply(mk("go_on",         0, 4'b0000, 16'd0, 5'b11000, 16'd0));
    run_ticks(236);
    apply(mk("go_237",        0, 4'b0100, 16'd0, 5'b11000, 16'd0));
    apply(mk("done_237",      0, 4'b0001, 16'd0, 5'b00100, 16'd237));
    apply(mk("done_react",    0, 4'b0001, 16'd0, 5'b00100, 16'd237));

    // restart from DONE (start beats react), start during WAIT ignored
    apply(mk("restart",       0, 4'b0011, 16'd7, 5'b10000, 16'd237));
    run_ticks(3);
    drv(4'b0110, 16'd2);
    run_ticks(2);
    apply(mk("wait_7th_tick", 0, 4'b0100, 16'd0, 5'b10000, 16'd237));
    apply(mk("go_after_7",    0, 4'b0000, 16'd0, 5'b11000, 16'd237));

    // reset mid-GO at ms_cnt=50, then clean round
    run_ticks(49);
    apply(mk("go_50",         0, 4'b0100, 16'd0, 5'b11000, 16'd237));
    apply(mk("rst_mid_go",    0, 4'b1100, 16'd0, 5'b00000, 16'd0));
    apply(mk("start_post_rst",0, 4'b0010, 16'd2, 5'b10000, 16'd0));
    apply(mk("clean_t1",      0, 4'b0100, 16'd0, 5'b10000, 16'd0));
    apply(mk("clean_t2",      0, 4'b0100, 16'd0, 5'b10000, 16'd0));
    apply(mk("clean_go",      0, 4'b0000, 16'd0, 5'b11000, 16'd0));
    run_ticks(2);
    apply(mk("clean_go_3",    0, 4'b0100, 16'd0, 5'b11000, 16'd0));
    apply(mk("clean_done_3",  0, 4'b0001, 16'd0, 5'b00100, 16'd3));

    // false start
    apply(mk("fs_start",      0, 4'b0010, 16'd100, 5'b10000, 16'd3));
    run_ticks(39);
    apply(mk("fs_wait_40",    0, 4'b0100, 16'd0, 5'b10000, 16'd3));
    apply(mk("fs_early",      0, 4'b0001, 16'd0, 5'b00010, 16'd3));
    apply(mk("early_react",   0, 4'b0001, 16'd0, 5'b00010, 16'd3));
    apply(mk("early_restart", 0, 4'b0011, 16'd4, 5'b10000, 16'd3));

    // react on the WAIT match cycle
    run_ticks(3);
    apply(mk("match_wait_4",  0, 4'b0100, 16'd0, 5'b10000, 16'd3));
    apply(mk("match_react",   0, 4'b0001, 16'd0, 5'b00010, 16'd3));

    // zero delay reaches GO one cycle after WAIT entry
    apply(mk("zero_start",    0, 4'b0010, 16'd0, 5'b10000, 16'd3));
    apply(mk("zero_go",       0, 4'b0000, 16'd0, 5'b11000, 16'd3));
    apply(mk("zero_done",     0, 4'b0001, 16'd0, 5'b00100, 16'd0));

    // timeout with MAX_MS=20
    apply(mk("b_rst",         1, 4'b1000, 16'd0, 5'b00000, 16'd0));
    apply(mk("b_start",       1, 4'b0010, 16'd3, 5'b10000, 16'd0));
    run_ticks(3);
    apply(mk("b_go",          1, 4'b0000, 16'd0, 5'b11000, 16'd0));
    run_ticks(19);
    apply(mk("b_go_20",       1, 4'b0100, 16'd0, 5'b11000, 16'd0));
    apply(mk("b_timeout",     1, 4'b0100, 16'd0, 5'b00101, 16'd20));

    // react coincident with ms_cnt==MAX_MS
    apply(mk("b_restart",     1, 4'b0010, 16'd0, 5'b10000, 16'd20));
    apply(mk("b_go2",         1, 4'b0000, 16'd0, 5'b11000, 16'd20));
    run_ticks(20);
    apply(mk("b_react_at_max",1, 4'b0001, 16'd0, 5'b00100, 16'd20));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
